// File: rtl/strobe_debounce_gen_pkg.sv
// Shared types and constants for the strobe debounce generator.
package strobe_debounce_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned DEF_DEBOUNCE = 4;
  localparam int unsigned DEF_GAP      = 16;
  localparam int unsigned DEF_CNT_W    = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/strobe_debounce_gen_debounce_sync.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module debounce_sync
  import strobe_debounce_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_evt
);

  localparam int unsigned CW = clog2(DEBOUNCE + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          settled;

  assign settled  = (cnt == CW'(DEBOUNCE - 1));
  // Fires in the same cycle the level register is loaded with a 1.
  assign rise_evt = s2 && !level && settled;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (settled) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/strobe_debounce_gen.sv
// Debounced single-cycle strobe generator with a holdoff window and a
// saturating count of rises suppressed during holdoff.
module strobe_debounce_gen
  import strobe_debounce_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
  parameter int unsigned GAP      = DEF_GAP,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_raw,
  input  logic             io_enable,
  input  logic             io_clr,
  output logic             io_strobe,
  output logic             io_level,
  output logic             io_busy,
  output logic [CNT_W-1:0] io_dropped
);

  localparam int unsigned GW = clog2(GAP);

  state_t           state;
  logic [GW-1:0]    gap;
  logic             rise_evt;
  logic [CNT_W-1:0] drop_base;

  debounce_sync #(
    .DEBOUNCE(DEBOUNCE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .raw     (io_raw),
    .level   (io_level),
    .rise_evt(rise_evt)
  );

  assign io_busy = (state == HOLD);

  // Clear takes effect before a coincident drop increment.
  always_comb begin
    drop_base = io_dropped;
    if (io_clr) drop_base = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gap        <= '0;
      io_strobe  <= 1'b0;
      io_dropped <= '0;
    end else begin
      io_strobe <= 1'b0;
      if (io_clr) io_dropped <= '0;
      case (state)
        IDLE: begin
          if (rise_evt && io_enable) begin
            io_strobe <= 1'b1;
            state     <= HOLD;
            gap       <= GW'(GAP - 2);
          end
        end
        HOLD: begin
          if (gap == '0) state <= IDLE;
          else           gap   <= gap - GW'(1);
          if (rise_evt && (drop_base != '1)) io_dropped <= drop_base + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_debounce_gen.sv
// Directed scoreboard bench for strobe_debounce_gen (default and CNT_W=2 instances).
module tb_strobe_debounce_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_raw;
  logic       io_enable;
  logic       io_clr;
  logic       io_strobe, io_level, io_busy;
  logic [7:0] io_dropped;
  logic       strobe2, level2, busy2;
  logic [1:0] dropped2;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  strobe_debounce_gen dut (
    .clk       (clk),
    .reset     (reset),
    .io_raw    (io_raw),
    .io_enable (io_enable),
    .io_clr    (io_clr),
    .io_strobe (io_strobe),
    .io_level  (io_level),
    .io_busy   (io_busy),
    .io_dropped(io_dropped)
  );

  strobe_debounce_gen #(
    .CNT_W(2)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .io_raw    (io_raw),
    .io_enable (io_enable),
    .io_clr    (io_clr),
    .io_strobe (strobe2),
    .io_level  (level2),
    .io_busy   (busy2),
    .io_dropped(dropped2)
  );

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard_empty: observed %0d expected none", phase, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s %s: observed %0d expected %0d", phase, e.tag, obs, e.val);
      end
    end
  endtask

  // Queue expectations for the coming edge, clock it, then compare.
  task automatic step(input logic x_strobe, input logic x_level, input logic x_busy,
                      input logic [31:0] x_drop, input logic [31:0] x_drop2);
    sb.push_back('{tag: "strobe",   val: 32'(x_strobe)});
    sb.push_back('{tag: "level",    val: 32'(x_level)});
    sb.push_back('{tag: "busy",     val: 32'(x_busy)});
    sb.push_back('{tag: "dropped",  val: x_drop});
    sb.push_back('{tag: "dropped2", val: x_drop2});
    @(posedge clk);
    #1;
    chk(32'(io_strobe));
    chk(32'(io_level));
    chk(32'(io_busy));
    chk(32'(io_dropped));
    chk(32'(dropped2));
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned m8, m2;
    logic st, lv, bz, dr;

    reset     = 1'b1;
    io_raw    = 1'b0;
    io_enable = 1'b1;
    io_clr    = 1'b0;

    phase = "reset";
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 1'b0;

    phase = "latency";
    io_raw = 1'b1;
    for (int e = 0; e <= 20; e++)
      step(e == 5, e >= 5, (e >= 5) && (e <= 19), 0, 0);
    io_raw = 1'b0;
    idle_ticks(10);

    phase = "glitch";
    for (int e = 0; e <= 11; e++) begin
      io_raw = (e <= 2);
      step(0, 0, 0, 0, 0);
    end

    phase = "disabled";
    io_enable = 1'b0;
    io_raw    = 1'b1;
    for (int e = 0; e <= 5; e++)
      step(0, e >= 5, 0, 0, 0);
    io_enable = 1'b1;
    io_raw    = 1'b0;
    idle_ticks(10);

    phase = "gap_drop";
    for (int e = 0; e <= 26; e++) begin
      io_raw = (e <= 4) || ((e >= 10) && (e <= 14)) || (e >= 20);
      step((e == 5) || (e == 25),
           ((e >= 5) && (e <= 9)) || ((e >= 15) && (e <= 19)) || (e >= 25),
           ((e >= 5) && (e <= 19)) || (e >= 25),
           32'(e >= 15), 32'(e >= 15));
    end
    io_raw = 1'b0;
    idle_ticks(30);

    phase = "clear";
    io_clr = 1'b1;
    step(0, 0, 0, 0, 0);
    io_clr = 1'b0;

    // Period-8 raw square wave: rises at 5+8k, strobe every 16, drop in between.
    phase = "saturate_clr_reset";
    m8 = 0;
    m2 = 0;
    for (int e = 0; e <= 112; e++) begin
      io_raw = (e <= 110) && ((e % 8) < 4);
      io_clr = (e == 93);
      reset  = (e == 111);
      st = (e >= 5) && (((e - 5) % 16) == 0);
      dr = (e >= 13) && (((e - 13) % 16) == 0);
      lv = (e >= 5) && (((e % 8) >= 5) || ((e % 8) == 0));
      bz = (e >= 5) && (((e - 5) % 16) <= 14);
      if (io_clr) begin
        m8 = 0;
        m2 = 0;
      end
      if (dr) begin
        if (m8 < 255) m8++;
        if (m2 < 3) m2++;
      end
      if (e >= 111) begin
        st = 1'b0;
        lv = 1'b0;
        bz = 1'b0;
        m8 = 0;
        m2 = 0;
      end
      step(st, lv, bz, m8, m2);
    end
    reset  = 1'b0;
    io_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
